jt6295_rom_arb: RTL and testbench

//  Shares the single sample ROM port between the phrase-header fetcher (jt6295_ctrl) and the four ADPCM channels.
//  One outstanding ROM access at a time. Header fetch has fixed top priority; channels are served round-robin.
//  A one-entry last-address cache answers repeated reads without a ROM cycle. Sits between the ctrl/channel

---
 rtl/jt6295_pkg.sv | 18 +
 rtl/jt6295_rom_arb_if.sv | 28 ++
 rtl/jt6295_rr_pick.sv | 31 +++
 rtl/jt6295_rom_arb.sv | 151 +++++++++++++++
 tb/tb_jt6295_rom_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 ROM arbiter.
package jt6295_pkg;

   localparam int AW_DEF  = 18;
   localparam int CHN_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_t;

   // Requester index: channels 0..CHN-1, header fetcher above them
   typedef logic [2:0] req_idx_t;
   localparam req_idx_t CTRL_IDX = 3'd4;

endpackage

// File: rtl/jt6295_rom_arb_if.sv
// Requester and ROM-side bus of the sample ROM arbiter.
interface jt6295_rom_arb_if #(
   parameter int AW  = 18,
   parameter int CHN = 4
);
   logic              ctrl_req;
   logic [9:0]        ctrl_addr;
   logic [7:0]        ctrl_data;
   logic              ctrl_ok;
   logic [CHN-1:0]    ch_req;
   logic [CHN*AW-1:0] ch_addr;
   logic [CHN*8-1:0]  ch_data;
   logic [CHN-1:0]    ch_ok;
   logic [AW-1:0]     rom_addr;
   logic              rom_cs;
   logic [7:0]        rom_data;
   logic              rom_ok;

   modport slave (
      input  ctrl_req, ctrl_addr, ch_req, ch_addr, rom_data, rom_ok,
      output ctrl_data, ctrl_ok, ch_data, ch_ok, rom_addr, rom_cs
   );

   modport master (
      output ctrl_req, ctrl_addr, ch_req, ch_addr, rom_data, rom_ok,
      input  ctrl_data, ctrl_ok, ch_data, ch_ok, rom_addr, rom_cs
   );
endinterface

// File: rtl/jt6295_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclic.
module jt6295_rr_pick #(
   parameter int CHN = 4,
   parameter int PW  = $clog2(CHN)
) (
   input  logic [CHN-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [CHN-1:0] gnt,
   output logic [PW-1:0]  idx,
   output logic           any
);

   // Scan from ptr upward; the first hit locks out later candidates
   always_comb begin
      int   k;
      logic take;
      gnt  = {CHN{1'b0}};
      idx  = {PW{1'b0}};
      any  = 1'b0;
      k    = 0;
      take = 1'b0;
      for (int i = 0; i < CHN; i++) begin
         k      = (int'(ptr) + i) % CHN;
         take   = !any && req[k];
         gnt[k] = gnt[k] | take;
         idx    = take ? k[PW-1:0] : idx;
         any    = any | take;
      end
   end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Sample ROM arbiter: header fetch first, channels round-robin, one-entry
// last-address cache, one outstanding ROM access.
module jt6295_rom_arb
   import jt6295_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int CHN    = CHN_DEF,
   parameter bit HIT_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   jt6295_rom_arb_if.slave       bus,
   output logic                  busy
);

   localparam int PW = $clog2(CHN);

   arb_state_t        state, state_nxt;
   logic [PW-1:0]     rr_ptr, pick_idx;
   logic [CHN-1:0]    pick_gnt, gnt_oh;
   logic              pick_any, req_any, hit;
   req_idx_t          req_idx, gnt_idx;
   logic [AW-1:0]     req_addr, last_addr, rom_addr;
   logic [7:0]        last_data, ctrl_data;
   logic [CHN*8-1:0]  ch_data;
   logic [CHN-1:0]    ch_ok;
   logic              valid, no_cache, ctrl_ok, rom_cs;

   jt6295_rr_pick #(.CHN(CHN), .PW(PW)) u_pick (
      .req (bus.ch_req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign bus.ctrl_data = ctrl_data;
   assign bus.ctrl_ok   = ctrl_ok;
   assign bus.ch_data   = ch_data;
   assign bus.ch_ok     = ch_ok;
   assign bus.rom_addr  = rom_addr;
   assign bus.rom_cs    = rom_cs;

   // Request selection, cache lookup and next state
   always_comb begin
      req_any   = bus.ctrl_req | pick_any;
      req_idx   = 3'd0;
      req_addr  = {AW{1'b0}};
      if (bus.ctrl_req) begin
         req_idx  = CTRL_IDX;
         req_addr = {{(AW-10){1'b0}}, bus.ctrl_addr};
      end else if (pick_any) begin
         req_idx  = req_idx_t'(pick_idx);
         req_addr = bus.ch_addr[int'(pick_idx)*AW +: AW];
      end else begin
         req_idx  = 3'd0;
         req_addr = {AW{1'b0}};
      end
      // A flush in the lookup cycle forces a miss
      hit       = HIT_EN && valid && (req_addr == last_addr) && !flush;
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_any) state_nxt = hit ? ST_ACK : ST_SETUP;
            else         state_nxt = ST_IDLE;
         end
         ST_SETUP: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (bus.rom_ok) state_nxt = ST_ACK;
            else            state_nxt = ST_WAIT;
         end
         ST_ACK:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, ROM port, cache entry and per-requester data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         rr_ptr    <= {PW{1'b0}};
         gnt_idx   <= 3'd0;
         gnt_oh    <= {CHN{1'b0}};
         rom_addr  <= {AW{1'b0}};
         rom_cs    <= 1'b0;
         last_addr <= {AW{1'b0}};
         last_data <= 8'd0;
         valid     <= 1'b0;
         no_cache  <= 1'b0;
         ctrl_data <= 8'd0;
         ctrl_ok   <= 1'b0;
         ch_data   <= {(CHN*8){1'b0}};
         ch_ok     <= {CHN{1'b0}};
      end else begin
         state   <= state_nxt;
         busy    <= (state_nxt != ST_IDLE);
         ctrl_ok <= 1'b0;
         ch_ok   <= {CHN{1'b0}};
         if (flush) valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  gnt_idx  <= req_idx;
                  gnt_oh   <= bus.ctrl_req ? {CHN{1'b0}} : pick_gnt;
                  no_cache <= 1'b0;
                  if (hit) begin
                     if (bus.ctrl_req) begin
                        ctrl_data <= last_data;
                        ctrl_ok   <= 1'b1;
                     end else begin
                        ch_data[int'(pick_idx)*8 +: 8] <= last_data;
                        ch_ok <= pick_gnt;
                     end
                  end else begin
                     rom_addr <= req_addr;
                     rom_cs   <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               if (flush) no_cache <= 1'b1;
            end
            ST_WAIT: begin
               if (flush) no_cache <= 1'b1;
               if (bus.rom_ok) begin
                  rom_cs    <= 1'b0;
                  last_addr <= rom_addr;
                  last_data <= bus.rom_data;
                  // Data fetched across a flush may predate the bank switch
                  valid     <= HIT_EN && !flush && !no_cache;
                  if (gnt_idx == CTRL_IDX) begin
                     ctrl_data <= bus.rom_data;
                     ctrl_ok   <= 1'b1;
                  end else begin
                     ch_data[int'(gnt_idx[PW-1:0])*8 +: 8] <= bus.rom_data;
                     ch_ok <= gnt_oh;
                  end
               end
            end
            ST_ACK: begin
               if (gnt_idx != CTRL_IDX)
                  rr_ptr <= gnt_idx[PW-1:0] + {{(PW-1){1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb; ROM model returns addr[7:0]+0x11+bank one cycle late.
module tb_jt6295_rom_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       busy;
   logic [7:0] rom_q;
   logic [7:0] bank;
   int         n_assert = 0;
   int         n_fail   = 0;

   jt6295_rom_arb_if #(.AW(18), .CHN(4)) bus();

   jt6295_rom_arb #(.AW(18), .CHN(4), .HIT_EN(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= bus.rom_addr[7:0] + 8'h11 + bank;
   assign bus.rom_data = rom_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] chd(input int i);
      return bus.ch_data[i*8 +: 8];
   endfunction

   task automatic set_ch(input int i, input logic [17:0] a);
      bus.ch_addr[i*18 +: 18] = a;
   endtask

   task automatic wait_ok(input string tag, input int exp_lat);
      int lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (bus.ctrl_ok || bus.ch_ok != 4'b0000) lat = i;
      end
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   int         ord [5] = '{0, 1, 2, 3, 0};
   logic [7:0] dat [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h16};

   initial begin
      rst = 1'b1; flush = 1'b0; bank = 8'h00;
      bus.ctrl_req = 1'b0; bus.ctrl_addr = 10'h000;
      bus.ch_req = 4'b0000; bus.ch_addr = 72'd0; bus.rom_ok = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rom_cs", bus.rom_cs, 1'b0);
      chk("rst_rom_addr", bus.rom_addr, 18'h00000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ok", {bus.ctrl_ok, bus.ch_ok}, 5'b00000);
      chk("rst_data", {bus.ctrl_data, bus.ch_data}, 40'd0);
      rst = 1'b0;

      // reset in the middle of a WAIT
      bus.rom_ok = 1'b0; set_ch(1, 18'h00777); bus.ch_req = 4'b0010;
      @(negedge clk);
      chk("mid_setup_cs", bus.rom_cs, 1'b1);
      chk("mid_setup_addr", bus.rom_addr, 18'h00777);
      @(negedge clk);
      chk("mid_wait_busy", busy, 1'b1);
      rst = 1'b1; #1;
      chk("mid_rst_cs", bus.rom_cs, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ok", {bus.ctrl_ok, bus.ch_ok}, 5'b00000);
      bus.ch_req = 4'b0000; bus.rom_ok = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // header fetch, rom_ok always high
      bus.ctrl_addr = 10'h013; bus.ctrl_req = 1'b1;
      @(negedge clk);
      chk("t2_rom_addr", bus.rom_addr, 18'h00013);
      chk("t2_rom_cs", bus.rom_cs, 1'b1);
      chk("t2_ok_c1", bus.ctrl_ok, 1'b0);
      @(negedge clk);
      chk("t2_setup_ignored", bus.ctrl_ok, 1'b0);
      @(negedge clk);
      chk("t2_ok_c3", bus.ctrl_ok, 1'b1);
      chk("t2_data", bus.ctrl_data, 8'h24);
      chk("t2_cs_off", bus.rom_cs, 1'b0);
      chk("t2_ch_ok", bus.ch_ok, 4'b0000);
      bus.ctrl_req = 1'b0;
      @(negedge clk);
      chk("t2_ok_pulse", bus.ctrl_ok, 1'b0);
      chk("t2_idle", busy, 1'b0);
      chk("t2_data_held", bus.ctrl_data, 8'h24);

      // round robin over all four channels
      set_ch(0, 18'h00100); set_ch(1, 18'h00201);
      set_ch(2, 18'h00302); set_ch(3, 18'h00403);
      bus.ch_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ok("t3_rr", 3);
         chk("t3_grant", bus.ch_ok, 32'd1 << ord[k]);
         chk("t3_no_ctrl", bus.ctrl_ok, 1'b0);
         chk("t3_data", chd(ord[k]), dat[k]);
         if (k < 4) begin
            bus.ch_req[ord[k]] = 1'b0;
            set_ch(ord[k], 18'h00505);
         end else begin
            bus.ch_req = 4'b0000;
         end
         @(negedge clk);
         chk("t3_ok_pulse", bus.ch_ok, 4'b0000);
         if (k < 4) bus.ch_req[ord[k]] = 1'b1;
      end

      // ctrl and ch2 together, then pointer check
      bus.ctrl_addr = 10'h055; set_ch(2, 18'h00322);
      bus.ctrl_req = 1'b1; bus.ch_req = 4'b0100;
      wait_ok("t4_ctrl", 3);
      chk("t4_ctrl_ok", bus.ctrl_ok, 1'b1);
      chk("t4_ctrl_only", bus.ch_ok, 4'b0000);
      chk("t4_ctrl_data", bus.ctrl_data, 8'h66);
      bus.ctrl_req = 1'b0;
      @(negedge clk);
      chk("t4_ctrl_pulse", bus.ctrl_ok, 1'b0);
      wait_ok("t4_ch2", 3);
      chk("t4_ch2_ok", bus.ch_ok, 4'b0100);
      chk("t4_ch2_data", chd(2), 8'h33);
      bus.ch_req = 4'b0000;
      @(negedge clk);
      set_ch(0, 18'h00010); set_ch(3, 18'h00033);
      bus.ch_req = 4'b1001;
      wait_ok("t4_ptr", 3);
      chk("t4_ptr_is_3", bus.ch_ok, 4'b1000);
      chk("t4_ch3_data", chd(3), 8'h44);
      bus.ch_req[3] = 1'b0;
      @(negedge clk);
      wait_ok("t4_wrap", 3);
      chk("t4_wrap_ch0", bus.ch_ok, 4'b0001);
      chk("t4_ch0_data", chd(0), 8'h21);
      bus.ch_req = 4'b0000;
      @(negedge clk);

      // last-address cache
      set_ch(1, 18'h2ABCD); bus.ch_req = 4'b0010;
      wait_ok("t5_miss", 3);
      chk("t5_miss_data", chd(1), 8'hDE);
      bus.ch_req = 4'b0000;
      @(negedge clk);
      set_ch(3, 18'h2ABCD); bus.ch_req = 4'b1000;
      @(negedge clk);
      chk("t5_hit_cs", bus.rom_cs, 1'b0);
      chk("t5_hit_ok", bus.ch_ok, 4'b1000);
      chk("t5_hit_data", chd(3), 8'hDE);
      chk("t5_ch1_held", chd(1), 8'hDE);
      bus.ch_req = 4'b0000;
      @(negedge clk);
      chk("t5_hit_idle", busy, 1'b0);
      flush = 1'b1; bank = 8'h01;
      @(negedge clk);
      flush = 1'b0; bus.ch_req = 4'b0010;
      @(negedge clk);
      chk("t5_flush_miss_cs", bus.rom_cs, 1'b1);
      chk("t5_flush_no_ok", bus.ch_ok, 4'b0000);
      wait_ok("t5_flush", 2);
      chk("t5_flush_data", chd(1), 8'hDF);
      bus.ch_req = 4'b0000;
      @(negedge clk);
      bus.ch_req = 4'b1000; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t5_flush_same_cycle_cs", bus.rom_cs, 1'b1);
      wait_ok("t5_fsc", 2);
      chk("t5_fsc_data", chd(3), 8'hDF);
      bus.ch_req = 4'b0000;
      @(negedge clk);

      // long ROM wait with a flush in the middle
      bus.rom_ok = 1'b0; set_ch(0, 18'h00042); bus.ch_req = 4'b0001;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("t6_addr", bus.rom_addr, 18'h00042);
         chk("t6_cs", bus.rom_cs, 1'b1);
         chk("t6_busy", busy, 1'b1);
         chk("t6_no_ok", bus.ch_ok, 4'b0000);
         if (i == 10) begin flush = 1'b1; bank = 8'h02; end
         if (i == 11) flush = 1'b0;
         @(negedge clk);
      end
      bus.rom_ok = 1'b1;
      wait_ok("t6_done", 1);
      chk("t6_ok", bus.ch_ok, 4'b0001);
      chk("t6_data", chd(0), 8'h55);
      bus.ch_req = 4'b0000;
      @(negedge clk);
      set_ch(2, 18'h00042); bus.ch_req = 4'b0100;
      @(negedge clk);
      chk("t6_not_cached_cs", bus.rom_cs, 1'b1);
      chk("t6_not_cached_ok", bus.ch_ok, 4'b0000);
      wait_ok("t6_refetch", 2);
      chk("t6_refetch_ok", bus.ch_ok, 4'b0100);
      chk("t6_refetch_data", chd(2), 8'h55);
      bus.ch_req = 4'b0000;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
